rom_fetch_unit: RTL and testbench
=================================

Name: rom_fetch_unit

Overview:
- Initiator side of the program ROM interface. Drives the ROM's chip-select and address, waits a fixed settle time, captures the 32-bit word, and presents it to the CPU core over a valid/ready handshake.
- Owns the fetch program counter (PC), including sequential increment with wrap-around and branch redirect with abort of an in-flight fetch.
- Sits between the instruction ROM and the decode stage.

Parameters:
- ADDR_WIDTH, 6, width of the ROM address and PC.
- DATA_WIDTH, 32, width of a ROM word.
- ROM_DEPTH, 32, number of valid words. Legal addresses are 0..ROM_DEPTH-1.
- WAIT_CYCLES, 1, extra cycles that rom_cs is held before rom_data is sampled. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = keep fetching, 0 = stop after the current word is consumed.
- branch_valid  input  1  one-cycle pulse requesting a PC redirect.
- branch_target  input  ADDR_WIDTH  new PC, qualified by branch_valid.
- instr_ready  input  1  consumer accepts the word.
- instr_valid  output  1  instr_data/instr_pc hold a valid word.
- instr_data  output  DATA_WIDTH  fetched word.
- instr_pc  output  ADDR_WIDTH  address instr_data came from.
- busy  output  1  1 in any state other than IDLE.
- fault  output  1  sticky; set by an out-of-range branch target.
- rom_cs  output  1  ROM chip select, registered.
- rom_address  output  ADDR_WIDTH  ROM address, registered.
- rom_data  input  DATA_WIDTH  ROM read data. Only sampled while rom_cs=1; may be Z otherwise.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; pc=0.
  - rom_cs=0; rom_address=0.
  - instr_valid=0; instr_data=0; instr_pc=0.
  - fault=0; busy=0; wait counter=0.
- States: IDLE, SETUP, WAIT, PRESENT.
- IDLE: if run=1 and fault=0, go to SETUP. rom_cs stays 0.
- SETUP (always one cycle):
  - rom_address<=pc; rom_cs<=1; cnt<=WAIT_CYCLES.
  - Go to WAIT.
- WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - Else:
    - instr_data<=rom_data; instr_pc<=rom_address; instr_valid<=1.
    - rom_cs<=0.
    - pc<=pc+1, or pc<=0 if pc==ROM_DEPTH-1.
    - Go to PRESENT.
  - rom_cs is high for exactly WAIT_CYCLES+1 cycles per fetch. rom_address is stable throughout.
- PRESENT:
  - Outputs are held stable while instr_ready=0.
  - On instr_valid & instr_ready: instr_valid<=0, then go to SETUP if run=1, else IDLE.
  - instr_data/instr_pc keep their last value after acceptance.
- Latency:
  - instr_valid rises WAIT_CYCLES+2 edges after the edge on which IDLE sees run=1, or after an accept edge.
  - Sustained throughput: one word per WAIT_CYCLES+3 cycles with instr_ready tied 1.
- Stopping:
  - run dropping during SETUP/WAIT does not abort; the word completes and is presented.
  - The FSM returns to IDLE after that word is accepted.
- Branch (branch_valid=1, any state):
  - Highest priority, including over a simultaneous accept.
  - rom_cs<=0; instr_valid<=0. Any captured or in-flight word is discarded.
  - If branch_target < ROM_DEPTH: pc<=branch_target; next state SETUP if run=1, else IDLE.
  - If branch_target >= ROM_DEPTH: fault<=1; pc unchanged; next state IDLE.
  - A discarded word never appears on instr_valid.
- fault:
  - While fault=1 the FSM stays in IDLE regardless of run.
  - Only reset clears fault.
  - A later in-range branch while faulted updates pc but does not restart fetching.
- Wrap-around: a fetch from ROM_DEPTH-1 leaves pc=0. pc never exceeds ROM_DEPTH-1.
- Reset mid-fetch: rom_cs and instr_valid drop immediately and asynchronously. Fetching restarts from address 0.

Test Plan:
- Reset, run=1, instr_ready=1, WAIT_CYCLES=1, ROM[0..2]=A0000000/A0000001/A0000002 -> instr_valid rises 3 edges after run is seen. Words appear with instr_pc 0,1,2, each 4 cycles apart. rom_cs is high 2 cycles per fetch.
- Hold instr_ready=0 for 10 cycles at instr_pc=1 -> instr_data stays A0000001, rom_cs=0, pc=2. Raising ready gives the next fetch at address 2.
- Branch to 5 during WAIT of the fetch at address 3 -> word 3 is never presented; rom_cs drops; next instr_pc=5.
- Branch to 31, then continue -> instr_pc sequence 31, 0, 1 (wrap).
- Branch to 40 with run=1 -> fault=1, busy=0, no further rom_cs; only reset_n low clears fault.
- Assert reset_n=0 while rom_cs=1 -> rom_cs, instr_valid and fault are 0 immediately. After release, the first instr_pc is 0.

Source files
------------

// File: rtl/rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// rom_fetch_unit : program ROM initiator with PC, branch redirect, valid/ready
// Revision 1.0
// ============================================================================
module rom_fetch_unit #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int ROM_DEPTH   = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  instr_ready,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy,
    output logic                  fault,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(ROM_DEPTH);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_WAIT    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [3:0]            r_cnt;
    logic                  w_target_ok;

    assign w_target_ok = ({1'b0, branch_target} < DEPTH_EXT);
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            rom_cs      <= 1'b0;
            rom_address <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
            fault       <= 1'b0;
        end else if (branch_valid) begin
            // Redirect wins over everything, including a same-cycle accept.
            rom_cs      <= 1'b0;
            instr_valid <= 1'b0;
            if (w_target_ok) begin
                r_pc    <= branch_target;
                r_state <= (run && !fault) ? S_SETUP : S_IDLE;
            end else begin
                fault   <= 1'b1;
                r_state <= S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run && !fault) begin
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    rom_address <= r_pc;
                    rom_cs      <= 1'b1;
                    r_cnt       <= WAIT_INIT;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        instr_data  <= rom_data;
                        instr_pc    <= rom_address;
                        instr_valid <= 1'b1;
                        rom_cs      <= 1'b0;
                        r_pc        <= (r_pc == LAST_ADDR) ? '0 : r_pc + ADDR_WIDTH'(1);
                        r_state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        r_state     <= run ? S_SETUP : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_rom_fetch_unit : directed self-checking bench for rom_fetch_unit
// Revision 1.0
// ============================================================================
module tb_rom_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        branch_valid;
    logic [5:0]  branch_target;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [5:0]  instr_pc;
    logic        busy;
    logic        fault;
    logic        rom_cs;
    logic [5:0]  rom_address;
    wire  [31:0] rom_data;

    logic [31:0] rom_mem [0:31];
    int checks = 0;
    int errors = 0;
    int cs_seen;

    always #5 clk = ~clk;

    assign rom_data = rom_cs ? rom_mem[rom_address[4:0]] : 'z;

    rom_fetch_unit #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .ROM_DEPTH  (32),
        .WAIT_CYCLES(1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .instr_ready  (instr_ready),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .busy         (busy),
        .fault        (fault),
        .rom_cs       (rom_cs),
        .rom_address  (rom_address),
        .rom_data     (rom_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance until the next presented word, then compare its address and data.
    task automatic wait_word(input string tag, input logic [5:0] epc, input logic [31:0] edata);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (instr_valid === 1'b1) break;
        end
        if (instr_valid !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL %s timeout observed=no_word expected=pc %0d", tag, epc);
        end else begin
            chk6({tag, "_pc"}, instr_pc, epc);
            chk32({tag, "_data"}, instr_data, edata);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA000_0000 | 32'(i);

        reset_n = 1'b0; run = 1'b0; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
        #12;
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_cs", rom_cs, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk32("rst_data", instr_data, 32'h0);
        chk6("rst_pc", instr_pc, 6'd0);
        chk6("rst_addr", rom_address, 6'd0);

        tick(); reset_n = 1'b1;
        tick(); tick();
        chk1("idle_busy", busy, 1'b0);

        // Start: valid must rise on the third edge after run is seen.
        run = 1'b1; instr_ready = 1'b1;
        tick();
        chk1("e0_busy", busy, 1'b1);
        chk1("e0_cs", rom_cs, 1'b0);
        tick();
        chk1("e1_cs", rom_cs, 1'b1);
        chk6("e1_addr", rom_address, 6'd0);
        tick();
        chk1("e2_cs", rom_cs, 1'b1);
        chk1("e2_valid", instr_valid, 1'b0);
        tick();
        chk1("e3_valid", instr_valid, 1'b1);
        chk32("e3_data", instr_data, 32'hA000_0000);
        chk6("e3_pc", instr_pc, 6'd0);
        chk1("e3_cs", rom_cs, 1'b0);
        tick();
        chk1("e4_valid", instr_valid, 1'b0);
        tick();
        chk1("e5_cs", rom_cs, 1'b1);
        chk6("e5_addr", rom_address, 6'd1);
        tick();
        chk1("e6_valid", instr_valid, 1'b0);
        tick();
        chk1("e7_valid", instr_valid, 1'b1);
        chk32("e7_data", instr_data, 32'hA000_0001);
        chk6("e7_pc", instr_pc, 6'd1);

        // Back-pressure: word 1 held for 10 cycles, ROM idle.
        instr_ready = 1'b0;
        cs_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rom_cs === 1'b1) cs_seen++;
        end
        chk6("hold_cs_cycles", 6'(cs_seen), 6'd0);
        chk1("hold_valid", instr_valid, 1'b1);
        chk32("hold_data", instr_data, 32'hA000_0001);
        chk6("hold_pc", instr_pc, 6'd1);
        instr_ready = 1'b1;
        tick();
        chk1("acc_valid", instr_valid, 1'b0);
        tick();
        chk6("next_addr", rom_address, 6'd2);
        tick(); tick();
        chk1("w2_valid", instr_valid, 1'b1);
        chk32("w2_data", instr_data, 32'hA000_0002);

        // Fetch of address 3: redirect during WAIT discards it.
        tick(); tick();
        chk6("w3_addr", rom_address, 6'd3);
        chk1("w3_cs", rom_cs, 1'b1);
        branch_valid = 1'b1; branch_target = 6'd5;
        tick();
        branch_valid = 1'b0;
        chk1("br_cs", rom_cs, 1'b0);
        chk1("br_valid", instr_valid, 1'b0);
        wait_word("br5", 6'd5, 32'hA000_0005);

        // Branch coincident with accept; branch wins, then wrap from 31.
        branch_valid = 1'b1; branch_target = 6'd31;
        tick();
        branch_valid = 1'b0;
        chk1("br31_valid", instr_valid, 1'b0);
        wait_word("wrap31", 6'd31, 32'hA000_001F);
        wait_word("wrap0", 6'd0, 32'hA000_0000);
        wait_word("wrap1", 6'd1, 32'hA000_0001);

        // Out-of-range branch faults and halts fetching.
        branch_valid = 1'b1; branch_target = 6'd40;
        tick();
        branch_valid = 1'b0;
        chk1("flt_fault", fault, 1'b1);
        chk1("flt_valid", instr_valid, 1'b0);
        chk1("flt_cs", rom_cs, 1'b0);
        cs_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rom_cs === 1'b1 || busy === 1'b1) cs_seen++;
        end
        chk6("flt_quiet", 6'(cs_seen), 6'd0);
        branch_valid = 1'b1; branch_target = 6'd3;
        tick();
        branch_valid = 1'b0;
        cs_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rom_cs === 1'b1 || busy === 1'b1) cs_seen++;
        end
        chk6("flt_inrange_quiet", 6'(cs_seen), 6'd0);
        chk1("flt_sticky", fault, 1'b1);

        #2 reset_n = 1'b0;
        #1;
        chk1("flt_rst_clear", fault, 1'b0);
        tick();
        reset_n = 1'b1;

        // Reset during an active ROM cycle.
        for (int n = 0; n < 20; n++) begin
            if (rom_cs === 1'b1) break;
            tick();
        end
        chk1("mid_cs_up", rom_cs, 1'b1);
        chk6("mid_addr", rom_address, 6'd0);
        #2 reset_n = 1'b0;
        #1;
        chk1("mid_rst_cs", rom_cs, 1'b0);
        chk1("mid_rst_valid", instr_valid, 1'b0);
        chk1("mid_rst_fault", fault, 1'b0);
        tick();
        reset_n = 1'b1;
        wait_word("restart0", 6'd0, 32'hA000_0000);

        // Dropping run mid-fetch completes the word, then idles.
        tick();
        run = 1'b0;
        wait_word("stop1", 6'd1, 32'hA000_0001);
        tick(); tick();
        chk1("stop_busy", busy, 1'b0);
        chk1("stop_cs", rom_cs, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
